// File: rtl/pnseq_checker_pkg.sv
// Shared types and constants for the PN sequence checker.
package pnseq_checker_pkg;

    localparam int MAX_ORDER = 15;
    localparam int ORDER_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SEARCH = 2'd2,
        LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/pnseq_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module pnseq_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pnseq_checker.sv
// PN sequence checker: self-synchronises a local LFSR to the received stream, then freewheels and counts errors.
// Optional statistics counters are built only when PNSEQ_CHK_STATS_EN is defined.
module pnseq_checker
    import pnseq_checker_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int LOCK_THRESH = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   i_pnseq_poly,
    input  logic [ORDER_W-1:0] i_pnseq_order,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               locked,
    output logic               err,
    output logic               sync_loss,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output state_t             state_dbg
);

    localparam int RUN_W  = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W  = $clog2(WINDOW);
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   poly_reg, rx_reg;
    logic [ORDER_W-1:0] order_reg, fill_cnt;
    logic [RUN_W-1:0]   run_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [WERR_W-1:0]  win_err;
    logic               pred, mismatch, bit_ok, order_ok;
    logic               fill_done, lock_hit, loss_hit, win_wrap, locked_bit;
    logic               locked_d, err_d, sync_loss_d;

    // in_valid qualifies in_bit for exactly one cycle; there is no ready, every valid bit is consumed
    // unless load is high in the same cycle, in which case load wins and the bit is dropped.
    assign bit_ok     = in_valid && !load;
    assign pred       = ^(rx_reg & poly_reg);
    assign mismatch   = pred ^ in_bit;
    assign order_ok   = (i_pnseq_order != '0) && (int'(i_pnseq_order) <= WIDTH)
                        && (int'(i_pnseq_order) <= MAX_ORDER);
    assign fill_done  = (state == FILL) && bit_ok && (fill_cnt == order_reg - ORDER_W'(1));
    assign lock_hit   = (state == SEARCH) && bit_ok && !mismatch
                        && (run_cnt == RUN_W'(LOCK_THRESH - 1));
    assign locked_bit = (state == LOCKED) && bit_ok;
    assign loss_hit   = locked_bit && mismatch && (win_err == WERR_W'(LOSS_THRESH - 1));
    assign win_wrap   = (win_cnt == WIN_W'(WINDOW - 1));
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (load) begin
            state_next = order_ok ? FILL : IDLE;
        end else begin
            case (state)
                FILL:    if (fill_done) state_next = SEARCH;
                SEARCH:  if (lock_hit)  state_next = LOCKED;
                LOCKED:  if (loss_hit)  state_next = SEARCH;
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        locked_d    = (state_next == LOCKED);
        err_d       = locked_bit && mismatch;
        sync_loss_d = loss_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked    <= 1'b0;
            err       <= 1'b0;
            sync_loss <= 1'b0;
        end else begin
            locked    <= locked_d;
            err       <= err_d;
            sync_loss <= sync_loss_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poly_reg  <= '0;
            order_reg <= '0;
            rx_reg    <= '0;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (load) begin
            poly_reg  <= i_pnseq_poly;
            order_reg <= i_pnseq_order;
            rx_reg    <= '0;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (in_valid) begin
            case (state)
                FILL: begin
                    rx_reg   <= {in_bit, rx_reg[WIDTH-1:1]};
                    fill_cnt <= fill_cnt + ORDER_W'(1);
                end
                SEARCH: begin
                    rx_reg  <= {in_bit, rx_reg[WIDTH-1:1]};
                    run_cnt <= mismatch ? '0 : run_cnt + RUN_W'(1);
                    if (lock_hit) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end
                end
                LOCKED: begin
                    // Freewheel on the prediction so a corrupted bit never enters the register.
                    rx_reg <= {pred, rx_reg[WIDTH-1:1]};
                    if (loss_hit) begin
                        run_cnt <= '0;
                        win_cnt <= '0;
                        win_err <= '0;
                    end else if (win_wrap) begin
                        win_cnt <= '0;
                        win_err <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        win_err <= win_err + WERR_W'(mismatch);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PNSEQ_CHK_STATS_EN
    pnseq_sat_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .en    (locked_bit),
        .cnt   (bit_cnt)
    );

    pnseq_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .en    (locked_bit && mismatch),
        .cnt   (err_cnt)
    );
`else
    assign bit_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: doc/pnseq_checker.md
# pnseq_checker

Receive-side counterpart of the channel-sounder PN generator. Takes a serial bit stream carrying an LFSR sequence of configurable polynomial and order (max 15). It self-synchronises a local LFSR to the stream, then freewheels it and counts bit errors. Sits after the correlator/demod path and reports lock, per-bit error pulses and BER statistics to the control registers.

## Interface
- WIDTH, 10, LFSR register width; poly uses the same MSB-aligned convention as the generator (order 6 on WIDTH 10: poly 10'b0000110000)
- LOCK_THRESH, 16, consecutive correct predictions required to declare lock
- WINDOW, 64, loss-detection window length in valid bits
- LOSS_THRESH, 8, errors within one window that force loss of lock
- CNT_W, 32, statistics counter width
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  latch poly/order, clear state and statistics
- i_pnseq_poly  in  WIDTH  feedback tap mask
- i_pnseq_order  in  4  sequence order
- in_valid  in  1  in_bit qualifier
- in_bit  in  1  received PN bit
- locked  out  1  high in LOCKED state
- err  out  1  one-cycle pulse: compared bit mismatched while LOCKED
- sync_loss  out  1  one-cycle pulse on LOCKED→SEARCH
- bit_cnt  out  CNT_W  bits compared while LOCKED
- err_cnt  out  CNT_W  errors while LOCKED

## Operation
- Register rx_reg[WIDTH-1:0]; prediction pred = ^(rx_reg & poly_reg); every shift is right with the new bit entering at MSB.
- States: IDLE, FILL, SEARCH, LOCKED. Reset → IDLE. Only load leaves IDLE.
- load: latch poly/order; clear rx_reg, all counters and statistics. Valid order (1..WIDTH) → FILL; otherwise → IDLE.
- FILL: each valid bit shifts in_bit into rx_reg; after order bits → SEARCH. No comparison is made.
- SEARCH: each valid bit compares in_bit against pred, then shifts in_bit into rx_reg. A match increments run_cnt; a mismatch clears it. When run_cnt reaches LOCK_THRESH → LOCKED, with window counters cleared.
- LOCKED: freewheel: rx_reg shifts in pred, never in_bit. err = pred ^ in_bit. bit_cnt increments on each valid bit, and err_cnt increments on each error.
- Window: win_cnt counts valid bits 0..WINDOW-1 and wraps. win_err counts errors and is cleared at the wrap. When win_err reaches LOSS_THRESH → SEARCH, pulse sync_loss and clear run_cnt. rx_reg keeps its contents, so no refill is needed.
- Statistics counters saturate at all-ones and are cleared only by load or reset.
- Simultaneous load and in_valid: load wins and the bit is discarded.
- in_valid low: no state, register or counter change.

## Timing
- All outputs registered. Reset values: locked=0, err=0, sync_loss=0, bit_cnt=0, err_cnt=0, state IDLE.
- err is valid 1 cycle after the qualifying in_valid.
- locked rises 1 cycle after the LOCK_THRESH-th consecutive match.
- sync_loss is a 1-cycle pulse in the same cycle locked falls.
- Counters update 1 cycle after the bit.
- Back-to-back in_valid every cycle is supported; no backpressure.
- Reset mid-operation returns to IDLE immediately (asynchronous). poly/order are cleared, so a new load is required.

## Configuration
- PNSEQ_CHK_STATS_EN defined: bit_cnt/err_cnt counters are built as described.
- Not defined: bit_cnt and err_cnt are tied to 0. err, locked and sync_loss are unchanged.

## Structure
- Shared package: state enum (IDLE/FILL/SEARCH/LOCKED), MAX_ORDER=15 constant, ORDER_W=4.
- One sub-module, pnseq_sat_cnt: saturating counter with clear and enable, instanced twice for bit_cnt and err_cnt.
- Run, window and fill counters stay inline.

## Test plan
- Reset, then load poly 10'h030, order 6; stream the generator sequence from seed 10'h010 → locked rises 1 cycle after valid bit 22 (6 fill + 16 matches); err stays 0.
- Locked; invert bit 100 only → exactly one err pulse, err_cnt=1, locked stays 1, no further errors (freewheel does not propagate the error).
- Locked; invert 8 bits inside one 64-bit window → sync_loss pulse on the 8th error; locked=0. Clean stream → relock after 16 matches with no refill.
- Locked; 7 errors in each of consecutive windows → never loses lock; err_cnt accumulates 7 per window.
- load with order 0 → stays IDLE, locked never asserts; load coincident with in_valid → bit ignored and fill count starts at 0.
- Drive in_valid with gaps (1 valid per 3 cycles) → same lock bit index as the first scenario. Without PNSEQ_CHK_STATS_EN: bit_cnt=err_cnt=0 throughout.
